// File: rtl/alu_ctrl.sv
// Issuing controller for a 16-bit combinational ALU: handshake, 4-entry register file, writeback.
// Optional ALU_FLAG_CHECK_EN adds a sticky flag_err output that cross-checks the ALU's neg/zer.
module alu_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [2:0]              instr_op,
    input  logic [$clog2(NREG)-1:0] instr_rd,
    input  logic [$clog2(NREG)-1:0] instr_rs1,
    input  logic [$clog2(NREG)-1:0] instr_rs2,
    input  logic                    instr_cin,
    input  logic                    ld_en,
    input  logic [$clog2(NREG)-1:0] ld_addr,
    input  logic [WIDTH-1:0]        ld_data,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [WIDTH-1:0]        dbg_data,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [2:0]              alu_op,
    output logic                    alu_cin,
    input  logic [WIDTH-1:0]        alu_w,
    input  logic                    alu_neg,
    input  logic                    alu_zer,
    output logic [WIDTH-1:0]        result,
    output logic                    neg_flag,
    output logic                    zer_flag,
    output logic                    done,
    output logic                    illegal_op
`ifdef ALU_FLAG_CHECK_EN
    ,
    output logic                    flag_err
`endif
);

    localparam int unsigned AW = $clog2(NREG);
    localparam logic [2:0] OpIllegal = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d, zer_q, zer_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        cin_d    = cin_q;
        rf_d     = rf_q;
        result_d = result_q;
        neg_d    = neg_q;
        zer_d    = zer_q;
        unique case (state_q)
            StIdle: begin
                // Load lands at the accept edge, so EXEC reads the fresh value.
                if (ld_en) rf_d[ld_addr] = ld_data;
                if (instr_valid) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    cin_d   = instr_cin;
                    state_d = (instr_op == OpIllegal) ? StWb : StExec;
                end
            end
            StExec: begin
                rf_d[rd_q] = alu_w;
                result_d   = alu_w;
                neg_d      = alu_neg;
                zer_d      = alu_zer;
                state_d    = StWb;
            end
            StWb: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            cin_q    <= 1'b0;
            rf_q     <= '{default: '0};
            result_q <= '0;
            neg_q    <= 1'b0;
            zer_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            cin_q    <= cin_d;
            rf_q     <= rf_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            zer_q    <= zer_d;
        end
    end

    always_comb begin
        instr_ready = (state_q == StIdle);
        done        = (state_q == StWb);
        illegal_op  = (state_q == StWb) && (op_q == OpIllegal);
        dbg_data    = rf_q[dbg_addr];
        result      = result_q;
        neg_flag    = neg_q;
        zer_flag    = zer_q;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = '0;
        alu_cin     = 1'b0;
        if (state_q == StExec) begin
            alu_a   = rf_q[rs1_q];
            alu_b   = rf_q[rs2_q];
            alu_op  = op_q;
            alu_cin = cin_q;
        end
    end

`ifdef ALU_FLAG_CHECK_EN
    logic flag_err_q, flag_err_d;
    logic flag_mismatch;

    always_comb begin
        flag_mismatch = ((alu_w == '0) != alu_zer) || (alu_w[WIDTH-1] != alu_neg);
        flag_err_d    = flag_err_q | ((state_q == StExec) && flag_mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flag_err_q <= 1'b0;
        else        flag_err_q <= flag_err_d;
    end

    assign flag_err = flag_err_q;
`endif

endmodule
